// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor PWM driver.
// Overcurrent protection is built only with MTR_DRV_OVR_PROT_EN.
package mtr_drv_pkg;

  localparam int CW             = 11;
  localparam int NONOVERLAP_DEF = 32;
  localparam int BLANK_DEF      = 128;
  localparam int OVR_LIMIT_DEF  = 4;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DUTY_MID = 11'h400;

  typedef enum logic {
    RUN,
    SHTDWN
  } ovr_state_e;

endpackage

// File: rtl/pwm_nonoverlap.sv
// Dead-time insertion for one half-bridge.
// Both gates stay low for NONOVERLAP clocks after any raw edge.
module pwm_nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter int NONOVERLAP = NONOVERLAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic force_low_i,
  output logic pwm1_o,
  output logic pwm2_o
);

  localparam int DW = 6;

  logic [DW-1:0] dt_q, dt_d;
  logic          prev_q;
  logic          pwm1_q, pwm1_d;
  logic          pwm2_q, pwm2_d;

  // Any raw edge, even mid dead-time, restarts the wait.
  always_comb begin
    dt_d = dt_q;
    if (raw_i != prev_q) begin
      dt_d = DW'(NONOVERLAP);
    end else if (dt_q != '0) begin
      dt_d = dt_q - 1'b1;
    end
    pwm1_d = !force_low_i && (dt_d == '0) && raw_i;
    pwm2_d = !force_low_i && (dt_d == '0) && !raw_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q   <= DW'(NONOVERLAP);
      prev_q <= 1'b0;
      pwm1_q <= 1'b0;
      pwm2_q <= 1'b0;
    end else begin
      dt_q   <= dt_d;
      prev_q <= raw_i;
      pwm1_q <= pwm1_d;
      pwm2_q <= pwm2_d;
    end
  end

  assign pwm1_o = pwm1_q;
  assign pwm2_o = pwm2_q;

endmodule

// File: rtl/mtr_drv.sv
// Two-side motor PWM driver with dead-time and period sync.
// MTR_DRV_OVR_PROT_EN adds the latched overcurrent shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int NONOVERLAP = NONOVERLAP_DEF,
  parameter int BLANK      = BLANK_DEF,
  parameter int OVR_LIMIT  = OVR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        PWM_synch,
  output logic        OVR_I_shtdwn
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_l, duty_r;
  logic [CW-1:0] shd_l_q, shd_l_d;
  logic [CW-1:0] shd_r_q, shd_r_d;
  logic          raw_l_q, raw_l_d;
  logic          raw_r_q, raw_r_d;
  logic          synch_q, synch_d;
  logic          force_low;
  logic          unused_lsb;

  // Signed speed mapped to unsigned duty centred on 0x400.
  assign duty_l     = {~lft_spd[11], lft_spd[10:1]};
  assign duty_r     = {~rght_spd[11], rght_spd[10:1]};
  assign unused_lsb = lft_spd[0] ^ rght_spd[0];

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    synch_d = (cnt_q == CNT_MAX);
    shd_l_d = shd_l_q;
    shd_r_d = shd_r_q;
    if (cnt_q == CNT_MAX) begin
      shd_l_d = duty_l;
      shd_r_d = duty_r;
    end
    raw_l_d = (cnt_q < shd_l_q);
    raw_r_d = (cnt_q < shd_r_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      synch_q <= 1'b0;
      shd_l_q <= DUTY_MID;
      shd_r_q <= DUTY_MID;
      raw_l_q <= 1'b0;
      raw_r_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      synch_q <= synch_d;
      shd_l_q <= shd_l_d;
      shd_r_q <= shd_r_d;
      raw_l_q <= raw_l_d;
      raw_r_q <= raw_r_d;
    end
  end

  assign PWM_synch = synch_q;

`ifdef MTR_DRV_OVR_PROT_EN
  localparam int FW = $clog2(OVR_LIMIT + 1);

  ovr_state_e    state_q, state_d;
  logic          flag_q, flag_d;
  logic          hit, flag_c;
  logic [FW-1:0] fcnt_q, fcnt_d, fcnt_inc;

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    fcnt_d   = fcnt_q;
    fcnt_inc = fcnt_q + 1'b1;
    hit      = (OVR_I_lft | OVR_I_rght) && (cnt_q >= CW'(BLANK));
    flag_c   = flag_q | hit;
    unique case (state_q)
      RUN: begin
        if (cnt_q == CNT_MAX) begin
          flag_d = 1'b0;
          fcnt_d = flag_c ? fcnt_inc : '0;
          if (flag_c && (fcnt_inc == FW'(OVR_LIMIT))) begin
            state_d = SHTDWN;
          end
        end else begin
          flag_d = flag_c;
        end
      end
      SHTDWN: state_d = SHTDWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flag_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Gates drop on the same edge the shutdown state is entered.
  assign force_low    = (state_d == SHTDWN);
  assign OVR_I_shtdwn = (state_q == SHTDWN);
`else
  localparam int unused_cfg = BLANK + OVR_LIMIT;
  logic unused_ovr;

  assign unused_ovr   = OVR_I_lft ^ OVR_I_rght;
  assign force_low    = 1'b0;
  assign OVR_I_shtdwn = 1'b0;
`endif

  pwm_nonoverlap #(
    .NONOVERLAP (NONOVERLAP)
  ) u_lft (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_i       (raw_l_q),
    .force_low_i (force_low),
    .pwm1_o      (PWM1_lft),
    .pwm2_o      (PWM2_lft)
  );

  pwm_nonoverlap #(
    .NONOVERLAP (NONOVERLAP)
  ) u_rght (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_i       (raw_r_q),
    .force_low_i (force_low),
    .pwm1_o      (PWM1_rght),
    .pwm2_o      (PWM2_rght)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: period/duty/dead-time/overcurrent model
// checked every cycle, plus hand-computed period totals.
module tb_mtr_drv;

  localparam int N     = 32;
  localparam int BLANK = 128;
  localparam int LIMIT = 4;
`ifdef MTR_DRV_OVR_PROT_EN
  localparam int PROT = 1;
`else
  localparam int PROT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] lft_spd, rght_spd;
  logic        OVR_I_lft, OVR_I_rght;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
  logic        PWM_synch, OVR_I_shtdwn;

  mtr_drv #(
    .NONOVERLAP (N),
    .BLANK      (BLANK),
    .OVR_LIMIT  (LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .PWM_synch    (PWM_synch),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int errs;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model state: counter, duties in effect, raw level of this
  // cycle, raw level and run length of the previous cycle.
  int m_cnt;
  int m_duty [2];
  int m_raw  [2];
  int m_pr   [2];
  int m_ps   [2];
  int m_shut, m_wrap, m_flag, m_nf;

  function automatic int duty_of(input logic [11:0] s);
    int v;
    v = int'($signed(s));
    return (v >>> 1) + 1024;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_shut = 0;
    m_wrap = 0;
    m_flag = 0;
    m_nf = 0;
    for (int s = 0; s < 2; s++) begin
      m_duty[s] = 1024;
      m_raw[s]  = 0;
      m_pr[s]   = 0;
      m_ps[s]   = 1;
    end
  endtask

  function automatic int exp_gate(input int s, input int lvl);
    return (m_shut == 0 && m_pr[s] == lvl && m_ps[s] >= N + 1) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_outs", int'({PWM1_lft, PWM2_lft, PWM1_rght,
                            PWM2_rght, PWM_synch, OVR_I_shtdwn}), 0);
    end else begin
      chk("PWM1_lft",  int'(PWM1_lft),  exp_gate(0, 1));
      chk("PWM2_lft",  int'(PWM2_lft),  exp_gate(0, 0));
      chk("PWM1_rght", int'(PWM1_rght), exp_gate(1, 1));
      chk("PWM2_rght", int'(PWM2_rght), exp_gate(1, 0));
      chk("PWM_synch", int'(PWM_synch), (m_wrap != 0 && m_cnt == 0) ? 1 : 0);
      chk("shtdwn",    int'(OVR_I_shtdwn), m_shut);
      for (int s = 0; s < 2; s++) begin
        int ns;
        ns = (m_raw[s] == m_pr[s]) ? ((m_ps[s] < 4096) ? m_ps[s] + 1 : m_ps[s]) : 1;
        m_pr[s] = m_raw[s];
        m_ps[s] = ns;
        m_raw[s] = (m_cnt < m_duty[s]) ? 1 : 0;
      end
      if (PROT != 0 && m_shut == 0) begin
        if ((OVR_I_lft | OVR_I_rght) && m_cnt >= BLANK) m_flag = 1;
        if (m_cnt == 2047) begin
          m_nf = (m_flag != 0) ? m_nf + 1 : 0;
          m_flag = 0;
          if (m_nf >= LIMIT) m_shut = 1;
        end
      end
      if (m_cnt == 2047) begin
        m_duty[0] = duty_of(lft_spd);
        m_duty[1] = duty_of(rght_spd);
      end
      m_cnt = (m_cnt + 1) % 2048;
      if (m_cnt == 0) m_wrap = 1;
    end
  end

  // High-cycle totals per period, latched at each sync pulse.
  int cur [4];
  int last [4];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cur[i] = 0;
        last[i] = 0;
      end
    end else begin
      if (PWM_synch) begin
        for (int i = 0; i < 4; i++) begin
          last[i] = cur[i];
          cur[i] = 0;
        end
      end
      cur[0] += int'(PWM1_lft);
      cur[1] += int'(PWM2_lft);
      cur[2] += int'(PWM1_rght);
      cur[3] += int'(PWM2_rght);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 4200; i++) begin
      if (m_cnt == v) return;
      step();
    end
    chk("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic wait_synch();
    for (int i = 0; i < 4200; i++) begin
      step();
      if (PWM_synch) return;
    end
    chk("wait_synch_timeout", 0, 1);
  endtask

  task automatic read_totals();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_lft();
    OVR_I_lft = 1'b1;
    step();
    OVR_I_lft = 1'b0;
  endtask

  int fault_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    int fh, sy;
    vec = 0;
    errs = 0;
    rst_n = 1'b0;
    lft_spd = 12'h000;
    rght_spd = 12'h000;
    OVR_I_lft = 1'b0;
    OVR_I_rght = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({PWM1_lft, PWM2_lft, PWM1_rght,
                             PWM2_rght, PWM_synch, OVR_I_shtdwn}), 0);
    rght_spd = 12'h7FF;
    rst_n = 1'b1;

    repeat (3) wait_synch();
    read_totals();
    chk("lft_zero_pwm1_hi", last[0], 992);
    chk("lft_zero_pwm2_hi", last[1], 992);
    chk("rght_max_pwm1_hi", last[2], 2015);
    chk("rght_max_pwm2_hi", last[3], 0);

    wait_cnt(100);
    lft_spd = 12'h400;
    wait_synch();
    read_totals();
    chk("lft_mid_change_same", last[0], 992);
    wait_synch();
    read_totals();
    chk("lft_new_duty_hi", last[0], 1504);

    for (int p = 0; p < 2; p++) begin
      wait_cnt(50);
      OVR_I_rght = 1'b1;
      step();
      OVR_I_rght = 1'b0;
      wait_cnt(2047);
      step();
      chk("blanked_no_sd", int'(OVR_I_shtdwn), 0);
    end

    for (int p = 0; p < 8; p++) begin
      if (fault_pat[p] != 0) begin
        wait_cnt(200);
        pulse_lft();
      end
      wait_cnt(2047);
      step();
      chk("broken_run_no_sd", int'(OVR_I_shtdwn), 0);
    end

    for (int p = 0; p < 4; p++) begin
      if (p < 3) begin
        wait_cnt(200);
        pulse_lft();
        wait_cnt(2047);
        step();
        chk("run_pre_sd", int'(OVR_I_shtdwn), 0);
      end else begin
        wait_cnt(2047);
        pulse_lft();
        chk("sd_after_4th", int'(OVR_I_shtdwn), PROT);
        chk("sd_gates", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}),
            (PROT != 0) ? 0 : 6);
      end
    end
    repeat (300) step();
    chk("sd_held", int'(OVR_I_shtdwn), PROT);

    wait_cnt(1000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'({PWM1_lft, PWM2_lft, PWM1_rght,
                                PWM2_rght, PWM_synch, OVR_I_shtdwn}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fh = -1;
    sy = -1;
    for (int k = 0; k < 2100 && sy < 0; k++) begin
      if (fh < 0 && (PWM1_lft | PWM2_lft | PWM1_rght | PWM2_rght)) fh = k;
      if (PWM_synch) sy = k;
      step();
    end
    chk("rst_low_hold", (fh >= N) ? 1 : 0, 1);
    chk("rst_cnt_restart", sy, 2048);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter: NONOVERLAP, default 32, dead-time in clk cycles (range 2..63).
REQ-002 Parameter: BLANK, default 128, count value below which overcurrent inputs are ignored in each PWM period.
REQ-003 Parameter: OVR_LIMIT, default 4, number of consecutive faulted PWM periods that triggers shutdown.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 lft_spd  in  12  signed left speed command from the balance controller.
REQ-007 rght_spd  in  12  signed right speed command from the balance controller.
REQ-008 OVR_I_lft  in  1  active-high overcurrent flag from the left bridge driver.
REQ-009 OVR_I_rght  in  1  active-high overcurrent flag from the right bridge driver.
REQ-010 PWM1_lft, PWM2_lft  out  1 each  left high-side and low-side gate drives.
REQ-011 PWM1_rght, PWM2_rght  out  1 each  right high-side and low-side gate drives.
REQ-012 PWM_synch  out  1  one-clk pulse marking the start of each PWM period.
REQ-013 OVR_I_shtdwn  out  1  latched overcurrent shutdown indicator.

Function
REQ-014 The block SHALL run an 11-bit free-running period counter cnt (0..2047, wraps to 0); PWM_synch SHALL be high exactly when cnt==0.
REQ-015 Duty per side SHALL be {~spd[11], spd[10:1]}, an unsigned 11-bit value with 0x400 at zero speed.
REQ-016 Duty SHALL be captured into a shadow register only when cnt==11'h7FF and applied from the next cnt==0; mid-period speed changes SHALL NOT alter the current period.
REQ-017 Raw PWM per side SHALL be registered high when cnt < duty, otherwise low.
REQ-018 On every raw-PWM transition, both outputs of that side SHALL go low for NONOVERLAP clocks; afterwards PWM1 = raw and PWM2 = ~raw.
REQ-019 A raw pulse or gap shorter than NONOVERLAP SHALL restart the dead-time, and the corresponding output SHALL never assert.
REQ-020 PWM1 and PWM2 of the same side SHALL never be high in the same cycle.
REQ-021 The overcurrent FSM SHALL have states RUN and SHTDWN.
REQ-022 In RUN, a per-period fault flag SHALL set when (OVR_I_lft|OVR_I_rght) is high and cnt >= BLANK.
REQ-023 At cnt==11'h7FF, the fault counter SHALL increment if the fault flag is set and clear if it is not; the fault flag SHALL then clear.
REQ-024 When the fault counter reaches OVR_LIMIT, the FSM SHALL enter SHTDWN.
REQ-025 In SHTDWN, all four PWM outputs SHALL be low from the next clock, and OVR_I_shtdwn SHALL be 1.
REQ-026 SHTDWN SHALL be exited only by rst_n.
REQ-027 An overcurrent assertion coinciding with the cnt==11'h7FF evaluation SHALL count toward the current period.

Reset
REQ-028 On rst_n low: cnt=0, shadow duties=0x400, all PWM outputs=0, PWM_synch=0, OVR_I_shtdwn=0, FSM=RUN, fault counter and fault flag=0, dead-time counters loaded to hold outputs low.
REQ-029 After reset release, outputs SHALL remain low for NONOVERLAP clocks before following raw PWM.
REQ-030 Reset asserted mid-period or in SHTDWN SHALL force the reset state immediately (asynchronously).

Configuration
REQ-031 Macro MTR_DRV_OVR_PROT_EN defined: REQ-021..REQ-027 SHALL be implemented.
REQ-032 Macro MTR_DRV_OVR_PROT_EN undefined: the FSM SHALL be omitted, OVR_I inputs SHALL be ignored, and OVR_I_shtdwn SHALL be tied 0.

Structure
REQ-033 Package mtr_drv_pkg SHALL hold the FSM state enum (RUN, SHTDWN), the period-width constant (11), and the default NONOVERLAP/BLANK/OVR_LIMIT values.
REQ-034 Sub-module pwm_nonoverlap (raw PWM in; PWM1/PWM2 out; dead-time counter; force-low input) SHALL be instantiated once per side.

Verification
REQ-035 lft_spd=0 -> duty 0x400; PWM1_lft and PWM2_lft each high 992 clocks per 2048-clock period, separated by 32-clock gaps.
REQ-036 rght_spd=12'h7FF -> PWM1_rght high 2015 clocks per period; PWM2_rght never high.
REQ-037 lft_spd changed 12'h000->12'h400 at cnt=100 -> current period unchanged; next period duty 0x600, PWM1_lft high 1536-32=1504 clocks.
REQ-038 OVR_I_lft pulsed at cnt=200 in 4 consecutive periods -> OVR_I_shtdwn=1 and all PWM outputs 0 one clock after the 4th cnt==0x7FF; state persists until rst_n.
REQ-039 OVR_I_rght pulsed at cnt=50 in every period -> no shutdown. Faults in 3 periods, then 1 clean period, then 3 more -> no shutdown.
REQ-040 rst_n pulsed at cnt=1000 -> outputs 0 immediately; after release, cnt restarts at 0 and outputs stay low 32 clocks.
